uart_rx: RTL and testbench

UART receive stage with 16x oversampling. It sits directly downstream of the baud-rate tick generator and consumes its one-clock `done` pulse as `s_tick`, 16 ticks per bit period. It synchronizes the asynchronous `rx` line, finds each start bit, samples every bit at mid-period, and presents each received word with a one-cycle valid pulse and a framing-error flag.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// rx_state_t is also the type of the receiver's state debug port.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_TICK    = 7;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for an asynchronous input.
// Both flops reset to RST_VAL so the output matches the line's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: finds the start bit, samples each bit at
// mid-period and reports every word with a one-clk rx_done pulse.
//
// Handshake: rx_done is a one-clk valid pulse with no ready; rx_dout and
// frame_err update on the same edge and hold until the next pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy,
  output rx_state_t       state_dbg
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            rx_s;
  rx_state_t       state_q;
  logic [4:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            armed_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A line held low after a bad stop bit must return high before
          // another start is accepted; otherwise a break repeats as frames.
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 5'(MID_TICK)) begin
              s_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 5'(OVERSAMPLE - 1)) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == NW'(DBIT - 1)) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == 5'(SB_TICK - 1)) begin
              state_q <= IDLE;
              s_q     <= '0;
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
              if (!rx_s) armed_q <= 1'b0;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_dout   = dout_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, randomized frames, and hand-built
// sequences for glitches, breaks, mid-frame reset and a 2-stop-bit variant.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DBIT    = 8;
  localparam int BIT_CLK = 64;
  localparam int LAT2    = MID_TICK + 1 + OVERSAMPLE * DBIT + 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic s_tick  = 1'b0;
  logic rx      = 1'b1;
  logic rx2     = 1'b1;

  logic [DBIT-1:0] rx_dout, rx_dout2;
  logic            rx_done, rx_done2;
  logic            frame_err, frame_err2;
  logic            busy, busy2;
  rx_state_t       state_dbg, state_dbg2;

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx),
    .rx_dout(rx_dout), .rx_done(rx_done), .frame_err(frame_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  uart_rx #(.DBIT(DBIT), .SB_TICK(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx2),
    .rx_dout(rx_dout2), .rx_done(rx_done2), .frame_err(frame_err2),
    .busy(busy2), .state_dbg(state_dbg2)
  );

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      s_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DBIT:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [DBIT:0] e;
    if (reset_n && rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious rx_done", 32'(rx_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rx_dout", 32'(rx_dout), 32'(e[DBIT-1:0]));
        check("frame_err", 32'(frame_err), 32'(e[DBIT]));
      end
    end
    if (reset_n && rx_done2) done2_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v, input bit on2);
    @(negedge clk);
    if (on2) rx2 = v;
    else rx = v;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DBIT-1:0] d, input logic stop,
                            input int nstop, input bit on2);
    drive_bit(1'b0, on2);
    for (int i = 0; i < DBIT; i++) drive_bit(d[i], on2);
    for (int k = 0; k < nstop; k++) drive_bit(stop, on2);
  endtask

  // Reference rule: a frame delivers its data bits LSB first and flags a
  // framing error exactly when its stop bit is low.
  function automatic logic [DBIT:0] model(input logic [DBIT-1:0] d, input logic stop);
    return {~stop, d};
  endfunction

  typedef struct {
    logic [DBIT-1:0] data;
    logic            stop;
    int              gap;
    logic [DBIT-1:0] exp_dout;
    logic            exp_ferr;
  } vec_t;

  vec_t vecs[4];

  // ---------------- test ----------------
  initial begin
    int c0;
    int t;
    bit got;
    logic [DBIT-1:0] prev;
    logic [DBIT-1:0] d;
    logic st;
    int gap;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 0, exp_dout: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_dout: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 2, exp_dout: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hC3, stop: 1'b0, gap: 1, exp_dout: 8'hC3, exp_ferr: 1'b1};

    // Reset state
    repeat (4) @(negedge clk);
    #1;
    check("reset rx_dout", 32'(rx_dout), 32'd0);
    check("reset rx_done", 32'(rx_done), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // Table frames, including 0x00 -> 0xFF back-to-back
    for (int i = 0; i < 4; i++) begin
      c0 = done_cnt;
      exp_q.push_back({vecs[i].exp_ferr, vecs[i].exp_dout});
      send_frame(vecs[i].data, vecs[i].stop, 1, 1'b0);
      check("table one pulse", 32'(done_cnt - c0), 32'd1);
      check("table busy after", 32'(busy), 32'd0);
      for (int g = 0; g < vecs[i].gap; g++) drive_bit(1'b1, 1'b0);
    end

    // Glitch: low for 3 ticks, then high
    prev = rx_dout;
    c0 = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch start seen", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (28) @(negedge clk);
    check("glitch back idle", 32'(state_dbg), 32'(IDLE));
    check("glitch busy", 32'(busy), 32'd0);
    check("glitch dout held", 32'(rx_dout), 32'(prev));
    repeat (BIT_CLK) @(negedge clk);
    check("glitch no pulse", 32'(done_cnt - c0), 32'd0);

    // Break: bad stop bit, then line held low for 4 bit times
    c0 = done_cnt;
    exp_q.push_back(model(8'h3C, 1'b0));
    send_frame(8'h3C, 1'b0, 1, 1'b0);
    repeat (4 * BIT_CLK) @(negedge clk);
    check("break single pulse", 32'(done_cnt - c0), 32'd1);
    check("break busy", 32'(busy), 32'd0);
    drive_bit(1'b1, 1'b0);
    c0 = done_cnt;
    exp_q.push_back(model(8'h55, 1'b1));
    send_frame(8'h55, 1'b1, 1, 1'b0);
    check("after break pulse", 32'(done_cnt - c0), 32'd1);

    // Randomized frames against the reference rule
    for (int i = 0; i < 12; i++) begin
      d   = DBIT'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) != 0);
      gap = st ? $urandom_range(0, 2) : $urandom_range(1, 2);
      c0 = done_cnt;
      exp_q.push_back(model(d, st));
      send_frame(d, st, 1, 1'b0);
      check("random one pulse", 32'(done_cnt - c0), 32'd1);
      for (int g = 0; g < gap; g++) drive_bit(1'b1, 1'b0);
    end

    // Mid-frame reset: leave non-reset outputs first, then abort 0x5A in bit 4
    exp_q.push_back(model(8'hE7, 1'b0));
    send_frame(8'hE7, 1'b0, 1, 1'b0);
    drive_bit(1'b1, 1'b0);
    c0 = done_cnt;
    d = 8'h5A;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    @(negedge clk);
    rx = d[4];
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset rx_dout", 32'(rx_dout), 32'd0);
    check("midreset rx_done", 32'(rx_done), 32'd0);
    check("midreset frame_err", 32'(frame_err), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    reset_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("midreset no pulse", 32'(done_cnt - c0), 32'd0);
    exp_q.push_back(model(8'h81, 1'b1));
    send_frame(8'h81, 1'b1, 1, 1'b0);
    check("post reset pulse", 32'(done_cnt - c0), 32'd1);

    // Two stop bits on the SB_TICK=32 instance; up to one tick may fall
    // inside the synchronizer/start-detect latency
    c0 = done2_cnt;
    got = 1'b0;
    t = 0;
    fork
      send_frame(8'h7E, 1'b1, 2, 1'b1);
      begin
        @(negedge clk);
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk);
          if (s_tick) t++;
          #1;
          if (rx_done2) begin
            got = 1'b1;
            break;
          end
        end
      end
    join
    check("sb32 pulse seen", 32'(got), 32'd1);
    check("sb32 latency ticks", 32'(t), (t == LAT2 + 1) ? 32'(LAT2 + 1) : 32'(LAT2));
    check("sb32 rx_dout", 32'(rx_dout2), 32'h7E);
    check("sb32 frame_err", 32'(frame_err2), 32'd0);
    repeat (BIT_CLK) @(negedge clk);
    check("sb32 one pulse", 32'(done2_cnt - c0), 32'd1);

    repeat (BIT_CLK) @(negedge clk);
    check("expected queue drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
